// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner:
// segment bit positions, blank patterns and the active-low hex font.
package seven_segment_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0]            BLANK_DATA   = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] BLANK_ENABLE = 4'b1111;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off; entry n sits at FONT[n].
  localparam logic [15:0][7:0] FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   dp;
  } display_t;

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Bundle of the load inputs and display pins of the seven-segment scanner.
interface seven_segment_scanner_if;
  import seven_segment_pkg::*;

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digitMask;
  logic [NUM_DIGITS-1:0]   decimalPoints;
  logic                    loadStrobe;
  logic [7:0]              sevenSegmentData;
  logic [NUM_DIGITS-1:0]   sevenSegmentEnable;
  logic                    frameStart;

  modport master (
    output value, digitMask, decimalPoints, loadStrobe,
    input  sevenSegmentData, sevenSegmentEnable, frameStart
  );

  modport slave (
    input  value, digitMask, decimalPoints, loadStrobe,
    output sevenSegmentData, sevenSegmentEnable, frameStart
  );

endinterface

// File: rtl/hex_to_segments.sv
// Combinational nibble-to-segment converter; output is active-low with the
// decimal point driven low when dp is requested.
module hex_to_segments
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] segments
);

  always_comb begin
    segments         = FONT[nibble];
    segments[SEG_DP] = ~dp;
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed four-digit display driver: shadow-loads a value on a strobe,
// commits it at frame boundaries and scans one digit per SCAN_DIV cycles.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_segment_scanner_if.slave  bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] divCount;
  logic [1:0]       digitIndex;
  logic             pendingFlag;
  display_t         pending_q;
  display_t         active_q;
  display_t         load_in;
  logic             tick;
  logic             boundary;
  logic             boundary_d;

  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_lit;
  logic [7:0]            cur_segments;
  logic [7:0]            data_next;
  logic [NUM_DIGITS-1:0] enable_next;

  assign load_in  = '{value: bus.value, mask: bus.digitMask, dp: bus.decimalPoints};
  assign tick     = (divCount == DIV_W'(SCAN_DIV - 1));
  assign boundary = tick && (digitIndex == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      divCount   <= '0;
      digitIndex <= '0;
    end else begin
      divCount <= tick ? '0 : divCount + 1'b1;
      if (tick) digitIndex <= digitIndex + 2'd1;
    end
  end

  // NOTE: pending/active are reset explicitly: a cleared mask is what blanks
  // the display, and a mid-scan reset must discard whatever was pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      active_q    <= '0;
      pendingFlag <= 1'b0;
    end else begin
      if (bus.loadStrobe) pending_q <= load_in;
      if (boundary) begin
        // A strobe landing on the boundary bypasses the pending stage.
        if (bus.loadStrobe)    active_q <= load_in;
        else if (pendingFlag)  active_q <= pending_q;
        pendingFlag <= 1'b0;
      end else if (bus.loadStrobe) begin
        pendingFlag <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_nibble = active_q.value[{digitIndex, 2'b00} +: 4];
    cur_dp     = active_q.dp[digitIndex];
    cur_lit    = active_q.mask[digitIndex];
  end

  hex_to_segments u_font (
    .nibble   (cur_nibble),
    .dp       (cur_dp),
    .segments (cur_segments)
  );

  // NOTE: defaults come first so every path assigns both outputs and no
  // latch is inferred.
  always_comb begin
    data_next   = BLANK_DATA;
    enable_next = BLANK_ENABLE;
    if (cur_lit) begin
      data_next   = cur_segments;
      enable_next = ~(NUM_DIGITS'(1) << digitIndex);
    end
  end

  // frameStart trails the boundary by two edges so it lines up with the
  // registered enable switching to digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sevenSegmentData   <= BLANK_DATA;
      bus.sevenSegmentEnable <= BLANK_ENABLE;
      bus.frameStart         <= 1'b0;
      boundary_d             <= 1'b0;
    end else begin
      bus.sevenSegmentData   <= data_next;
      bus.sevenSegmentEnable <= enable_next;
      boundary_d             <= boundary;
      bus.frameStart         <= boundary_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with SCAN_DIV=4: reset/idle,
// scan order, blanking/dp, tear-free commit, boundary strobe, mid-scan reset.
module tb_seven_segment_scanner;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  seven_segment_scanner_if bus ();

  seven_segment_scanner #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_sample(input string tag, input logic [3:0] en, input logic [7:0] data,
                              input logic fs);
    check({tag, "_en"},   32'(bus.sevenSegmentEnable), 32'(en));
    check({tag, "_data"}, 32'(bus.sevenSegmentData),   32'(data));
    check({tag, "_fs"},   32'(bus.frameStart),         32'(fs));
  endtask

  // Called at a negedge; returns at the negedge where frameStart is high.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frameStart && n < 40);
    check({tag, "_sync"}, 32'(bus.frameStart), 32'd1);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] m, input logic [3:0] d);
    bus.value         = v;
    bus.digitMask     = m;
    bus.decimalPoints = d;
    bus.loadStrobe    = 1'b1;
    @(negedge clk);
    bus.loadStrobe    = 1'b0;
  endtask

  // Starts at a frameStart sample and checks 16 samples; optionally strobes
  // value v (all lit, no dp) right after sample strobe_at.
  task automatic scan_frame(input string tag, input logic [3:0][7:0] data,
                            input logic [3:0][3:0] en, input int strobe_at,
                            input logic [15:0] v, input logic exp_pend);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (strobe_at >= 0 && k == strobe_at + 1) begin
        bus.loadStrobe = 1'b0;
        check({tag, "_pending"}, 32'(dut.pendingFlag), 32'(exp_pend));
      end
      check_sample(tag, en[k/4], data[k/4], k == 0);
      if (k == strobe_at) begin
        bus.value         = v;
        bus.digitMask     = 4'b1111;
        bus.decimalPoints = 4'b0000;
        bus.loadStrobe    = 1'b1;
      end
    end
  endtask

  initial begin
    int fs_count;
    int fs_first;
    vectors           = 0;
    miscompares       = 0;
    reset             = 1'b1;
    bus.value         = '0;
    bus.digitMask     = '0;
    bus.decimalPoints = '0;
    bus.loadStrobe    = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check_sample("reset", 4'b1111, 8'hFF, 1'b0);
    check("reset_div",     32'(dut.divCount),    32'd0);
    check("reset_idx",     32'(dut.digitIndex),  32'd0);
    check("reset_pending", 32'(dut.pendingFlag), 32'd0);
    reset    = 1'b0;
    fs_count = 0;
    fs_first = 0;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (i == 1) check("idle_div_start", 32'(dut.divCount), 32'd1);
      check("idle_en",   32'(bus.sevenSegmentEnable), 32'hF);
      check("idle_data", 32'(bus.sevenSegmentData),   32'hFF);
      if (bus.frameStart) begin
        fs_count++;
        if (fs_first == 0) fs_first = i;
      end
    end
    check("idle_fs_first", 32'(fs_first), 32'd17);
    check("idle_fs_count", 32'(fs_count), 32'd2);

    // Basic scan 16'h1A2F
    load(16'h1A2F, 4'b1111, 4'b0000);
    wait_frame("scan");
    scan_frame("scan", {8'hF9, 8'h88, 8'hA4, 8'h8E},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, -1, 16'h0, 1'b0);

    // Blanking and dp
    load(16'h8888, 4'b0101, 4'b0100);
    wait_frame("blank");
    scan_frame("blank", {8'hFF, 8'h00, 8'hFF, 8'h80},
               {4'b1111, 4'b1011, 4'b1111, 4'b1110}, -1, 16'h0, 1'b0);

    // Tear-free update: strobe FFFF while digit 1 is shown
    load(16'h0000, 4'b1111, 4'b0000);
    wait_frame("tear");
    scan_frame("tear_old", {8'hC0, 8'hC0, 8'hC0, 8'hC0},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4, 16'hFFFF, 1'b1);
    @(negedge clk);
    scan_frame("tear_new", {8'h8E, 8'h8E, 8'h8E, 8'h8E},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, -1, 16'h0, 1'b0);

    // Strobe exactly on the boundary tick
    @(negedge clk);
    scan_frame("bnd_old", {8'h8E, 8'h8E, 8'h8E, 8'h8E},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 14, 16'h1234, 1'b0);
    @(negedge clk);
    scan_frame("bnd_new", {8'hF9, 8'hA4, 8'hB0, 8'h99},
               {4'b0111, 4'b1011, 4'b1101, 4'b1110}, -1, 16'h0, 1'b0);

    // Reset while digit 2 is active with a strobe pending
    @(negedge clk);
    check("rst_sync", 32'(bus.frameStart), 32'd1);
    repeat (8) @(negedge clk);
    check_sample("rst_pre", 4'b1011, 8'hA4, 1'b0);
    load(16'h5555, 4'b1111, 4'b0000);
    check("rst_pre_pending", 32'(dut.pendingFlag), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_sample("rst_mid", 4'b1111, 8'hFF, 1'b0);
    check("rst_mid_div",     32'(dut.divCount),    32'd0);
    check("rst_mid_idx",     32'(dut.digitIndex),  32'd0);
    check("rst_mid_pending", 32'(dut.pendingFlag), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) check("rst_div_restart", 32'(dut.divCount), 32'd1);
      check("rst_after_en",   32'(bus.sevenSegmentEnable), 32'hF);
      check("rst_after_data", 32'(bus.sevenSegmentData),   32'hFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
